// File: rtl/clock_set_pkg.sv
// Shared types and constants for the time/date entry controller.
package clock_set_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    E_HOUR  = 3'd1,
    E_MIN   = 3'd2,
    E_SEC   = 3'd3,
    E_DAY   = 3'd4,
    E_MONTH = 3'd5,
    E_YEAR  = 3'd6,
    COMMIT  = 3'd7
  } state_t;

  localparam logic [2:0] FLD_HOUR  = 3'd0;
  localparam logic [2:0] FLD_MIN   = 3'd1;
  localparam logic [2:0] FLD_SEC   = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_MONTH = 3'd4;
  localparam logic [2:0] FLD_YEAR  = 3'd5;
  localparam logic [2:0] FLD_NONE  = 3'd7;

  localparam logic [4:0] HOUR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  localparam logic [4:0]  RST_HOUR  = 5'd0;
  localparam logic [5:0]  RST_MIN   = 6'd0;
  localparam logic [5:0]  RST_SEC   = 6'd0;
  localparam logic [4:0]  RST_DAY   = 5'd1;
  localparam logic [3:0]  RST_MONTH = 4'd1;
  localparam logic [13:0] RST_YEAR  = 14'd2024;

  // Gregorian leap rule; year 0 counts as leap (divisible by 400).
  function automatic logic is_leap(input logic [13:0] year);
    return (((year % 14'd4) == 14'd0) && ((year % 14'd100) != 14'd0)) ||
           ((year % 14'd400) == 14'd0);
  endfunction

endpackage

// File: rtl/days_in_month_calc.sv
// Combinational days-in-month lookup for a (month, year) pair.
module days_in_month_calc
  import clock_set_pkg::*;
(
  input  logic [3:0]  month,
  input  logic [13:0] year,
  output logic [4:0]  dim
);

  // Month length table with February depending on the leap rule.
  always_comb begin
    dim = 5'd31;
    case (month)
      4'd2:                    dim = is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Edit-session controller: preloads a shadow date/time from the live
// counter, lets the user step each field with wrap-around, and finishes
// with a one-cycle load pulse. Blink outputs drive the display mux.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int BLINK_DIV = 8,
  parameter int YEAR_MAX  = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  input  logic [4:0]  cur_hour,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  input  logic [4:0]  cur_day,
  input  logic [3:0]  cur_month,
  input  logic [13:0] cur_year,
  output logic [4:0]  set_hour,
  output logic [5:0]  set_min,
  output logic [5:0]  set_sec,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [13:0] set_year,
  output logic        load,
  output logic        editing,
  output logic [2:0]  field,
  output logic        field_blank
);

  localparam int              CNT_W    = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [13:0]     YEAR_TOP = 14'(YEAR_MAX);

  // Step a value by one inside [lo, hi], wrapping at both ends.
  function automatic logic [13:0] step_wrap(input logic [13:0] v,
                                            input logic [13:0] lo,
                                            input logic [13:0] hi,
                                            input logic        up);
    if (up) return (v >= hi) ? lo : v + 14'd1;
    else    return (v <= lo) ? hi : v - 14'd1;
  endfunction

  // Force a day into 1..dim.
  function automatic logic [4:0] clamp_day(input logic [4:0] d,
                                           input logic [4:0] dim);
    if (d == 5'd0) return 5'd1;
    if (d > dim)   return dim;
    return d;
  endfunction

  function automatic logic is_edit(input state_t s);
    return (s != IDLE) && (s != COMMIT);
  endfunction

  state_t           state, state_n;
  logic [3:0]       btn_p0, btn_p1;
  logic [3:0]       ev;
  logic             ev_mode, ev_inc, ev_dec, ev_cancel;
  logic             step_inc, step_dec;
  logic [3:0]       mon_cand;
  logic [13:0]      yr_cand;
  logic [4:0]       dim_cur, dim_nxt;
  logic [4:0]       hour_n, day_n;
  logic [5:0]       min_n, sec_n;
  logic [3:0]       month_n;
  logic [13:0]      year_n;
  logic             blink_clr;
  logic [CNT_W-1:0] blink_cnt;

  // Rising-edge events from the registered buttons {cancel, dec, inc, mode}.
  assign ev        = btn_p0 & ~btn_p1;
  assign ev_cancel = ev[3];
  assign ev_dec    = ev[2];
  assign ev_inc    = ev[1];
  assign ev_mode   = ev[0];
  assign step_inc  = ev_inc & ~ev_dec & ~ev_mode & ~ev_cancel;
  assign step_dec  = ev_dec & ~ev_inc & ~ev_mode & ~ev_cancel;

  days_in_month_calc u_dim_cur (
    .month (set_month),
    .year  (set_year),
    .dim   (dim_cur)
  );

  days_in_month_calc u_dim_nxt (
    .month (mon_cand),
    .year  (yr_cand),
    .dim   (dim_nxt)
  );

  // Month/year the shadow is about to take, so the day can be clamped in the same update.
  always_comb begin
    mon_cand = set_month;
    yr_cand  = set_year;
    case (state)
      IDLE: begin
        mon_cand = (cur_month == 4'd0 || cur_month > MONTH_MAX) ? 4'd1 : cur_month;
        yr_cand  = (cur_year > YEAR_TOP) ? 14'd0 : cur_year;
      end
      E_MONTH: begin
        if (step_inc || step_dec)
          mon_cand = 4'(step_wrap(14'(set_month), 14'd1, 14'(MONTH_MAX), step_inc));
      end
      E_YEAR: begin
        if (step_inc || step_dec)
          yr_cand = step_wrap(set_year, 14'd0, YEAR_TOP, step_inc);
      end
      default: ;
    endcase
  end

  // Next-state and shadow update; cancel beats mode beats inc/dec.
  always_comb begin
    state_n   = state;
    hour_n    = set_hour;
    min_n     = set_min;
    sec_n     = set_sec;
    day_n     = set_day;
    month_n   = set_month;
    year_n    = set_year;
    blink_clr = 1'b0;
    case (state)
      IDLE: begin
        if (ev_mode) begin
          state_n   = E_HOUR;
          hour_n    = (cur_hour > HOUR_MAX) ? 5'd0 : cur_hour;
          min_n     = (cur_min > MIN_MAX) ? 6'd0 : cur_min;
          sec_n     = (cur_sec > MIN_MAX) ? 6'd0 : cur_sec;
          month_n   = mon_cand;
          year_n    = yr_cand;
          day_n     = clamp_day(cur_day, dim_nxt);
          blink_clr = 1'b1;
        end
      end
      COMMIT: state_n = IDLE;
      default: begin
        if (ev_cancel) begin
          state_n = IDLE;
        end else if (ev_mode) begin
          blink_clr = 1'b1;
          case (state)
            E_HOUR:  state_n = E_MIN;
            E_MIN:   state_n = E_SEC;
            E_SEC:   state_n = E_DAY;
            E_DAY:   state_n = E_MONTH;
            E_MONTH: state_n = E_YEAR;
            default: state_n = COMMIT;
          endcase
        end else if (step_inc || step_dec) begin
          blink_clr = 1'b1;
          case (state)
            E_HOUR: hour_n = 5'(step_wrap(14'(set_hour), 14'd0, 14'(HOUR_MAX), step_inc));
            E_MIN:  min_n  = 6'(step_wrap(14'(set_min), 14'd0, 14'(MIN_MAX), step_inc));
            E_SEC:  sec_n  = 6'(step_wrap(14'(set_sec), 14'd0, 14'(MIN_MAX), step_inc));
            E_DAY:  day_n  = 5'(step_wrap(14'(set_day), 14'd1, 14'(dim_cur), step_inc));
            E_MONTH: begin
              month_n = mon_cand;
              day_n   = clamp_day(set_day, dim_nxt);
            end
            E_YEAR: begin
              year_n = yr_cand;
              day_n  = clamp_day(set_day, dim_nxt);
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State, button history and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      btn_p0    <= 4'd0;
      btn_p1    <= 4'd0;
      set_hour  <= RST_HOUR;
      set_min   <= RST_MIN;
      set_sec   <= RST_SEC;
      set_day   <= RST_DAY;
      set_month <= RST_MONTH;
      set_year  <= RST_YEAR;
    end else begin
      state     <= state_n;
      btn_p0    <= {btn_cancel, btn_dec, btn_inc, btn_mode};
      btn_p1    <= btn_p0;
      set_hour  <= hour_n;
      set_min   <= min_n;
      set_sec   <= sec_n;
      set_day   <= day_n;
      set_month <= month_n;
      set_year  <= year_n;
    end
  end

  // Blink timer: runs only while editing, restarts on any visible change.
  always_ff @(posedge clk) begin
    if (!rst_n || blink_clr || !is_edit(state_n)) begin
      blink_cnt   <= '0;
      field_blank <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      field_blank <= ~field_blank;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    load    = (state == COMMIT);
    editing = is_edit(state);
    case (state)
      E_HOUR:  field = FLD_HOUR;
      E_MIN:   field = FLD_MIN;
      E_SEC:   field = FLD_SEC;
      E_DAY:   field = FLD_DAY;
      E_MONTH: field = FLD_MONTH;
      E_YEAR:  field = FLD_YEAR;
      default: field = FLD_NONE;
    endcase
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for the time/date entry controller.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_mode, btn_inc, btn_dec, btn_cancel;
  logic [4:0]  cur_hour;
  logic [5:0]  cur_min;
  logic [5:0]  cur_sec;
  logic [4:0]  cur_day;
  logic [3:0]  cur_month;
  logic [13:0] cur_year;
  logic [4:0]  set_hour;
  logic [5:0]  set_min;
  logic [5:0]  set_sec;
  logic [4:0]  set_day;
  logic [3:0]  set_month;
  logic [13:0] set_year;
  logic        load, editing, field_blank;
  logic [2:0]  field;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int load_cnt = 0;
  int base;
  logic [39:0] ld_snap = '0;

  localparam logic [3:0] M_MODE = 4'b0001;
  localparam logic [3:0] M_INC  = 4'b0010;
  localparam logic [3:0] M_DEC  = 4'b0100;
  localparam logic [3:0] M_CAN  = 4'b1000;

  clock_set_ctrl #(.BLINK_DIV(8), .YEAR_MAX(9999)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .load(load), .editing(editing), .field(field), .field_blank(field_blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      ld_snap  <= {set_hour, set_min, set_sec, set_day, set_month, set_year};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic [3:0] m);
    {btn_cancel, btn_dec, btn_inc, btn_mode} = m;
    repeat (2) @(posedge clk);
    #1;
    {btn_cancel, btn_dec, btn_inc, btn_mode} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input int h, input int mi, input int s,
                         input int d, input int mo, input int y);
    cur_hour  = 5'(h);
    cur_min   = 6'(mi);
    cur_sec   = 6'(s);
    cur_day   = 5'(d);
    cur_month = 4'(mo);
    cur_year  = 14'(y);
  endtask

  // Enter edit mode and advance n fields past hour.
  task automatic enter_field(input int n);
    press(M_MODE);
    for (int i = 0; i < n; i++) press(M_MODE);
  endtask

  task automatic test_reset;
    chk_cnt++;
    if ({load, editing, field, field_blank} !== {1'b0, 1'b0, 3'd7, 1'b0}) begin
      $display("FAIL reset_status: load/editing/field/blank=%0d/%0d/%0d/%0d want 0/0/7/0",
               load, editing, field, field_blank);
    end else pass_cnt++;
    chk_cnt++;
    if ({set_hour, set_min, set_sec} !== {5'd0, 6'd0, 6'd0}) begin
      $display("FAIL reset_time: %0d:%0d:%0d want 0:0:0", set_hour, set_min, set_sec);
    end else pass_cnt++;
    chk_cnt++;
    if ({set_day, set_month, set_year} !== {5'd1, 4'd1, 14'd2024}) begin
      $display("FAIL reset_date: %0d/%0d/%0d want 1/1/2024", set_day, set_month, set_year);
    end else pass_cnt++;
  endtask

  task automatic test_commit;
    base = load_cnt;
    set_cur(13, 45, 7, 15, 6, 2025);
    press(M_MODE);
    chk_cnt++;
    if ({editing, field} !== {1'b1, 3'd0}) begin
      $display("FAIL enter_hour: editing/field=%0d/%0d want 1/0", editing, field);
    end else pass_cnt++;
    chk_cnt++;
    if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !==
        {5'd13, 6'd45, 6'd7, 5'd15, 4'd6, 14'd2025}) begin
      $display("FAIL preload: %0d:%0d:%0d %0d/%0d/%0d want 13:45:7 15/6/2025",
               set_hour, set_min, set_sec, set_day, set_month, set_year);
    end else pass_cnt++;
    for (int i = 0; i < 5; i++) press(M_MODE);
    chk_cnt++;
    if (field !== 3'd5) begin
      $display("FAIL walk_year: field=%0d want 5", field);
    end else pass_cnt++;
    btn_mode = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (load !== 1'b0) begin
      $display("FAIL load_early: load=%0d want 0", load);
    end else pass_cnt++;
    @(posedge clk); #1;
    btn_mode = 1'b0;
    chk_cnt++;
    if ({load, editing, field} !== {1'b1, 1'b0, 3'd7}) begin
      $display("FAIL load_pulse: load/editing/field=%0d/%0d/%0d want 1/0/7", load, editing, field);
    end else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({load, editing} !== 2'b00) begin
      $display("FAIL load_width: load/editing=%0d/%0d want 0/0", load, editing);
    end else pass_cnt++;
    repeat (3) @(posedge clk); #1;
    chk_cnt++;
    if (load_cnt - base !== 1) begin
      $display("FAIL load_count: pulses=%0d want 1", load_cnt - base);
    end else pass_cnt++;
    chk_cnt++;
    if (ld_snap !== {5'd13, 6'd45, 6'd7, 5'd15, 4'd6, 14'd2025}) begin
      $display("FAIL load_value: got %h want %h", ld_snap,
               {5'd13, 6'd45, 6'd7, 5'd15, 4'd6, 14'd2025});
    end else pass_cnt++;
  endtask

  task automatic test_time_wrap;
    set_cur(23, 0, 30, 10, 3, 2022);
    press(M_MODE);
    press(M_INC);
    chk_cnt++;
    if (set_hour !== 5'd0) begin
      $display("FAIL hour_inc_wrap: hour=%0d want 0", set_hour);
    end else pass_cnt++;
    press(M_DEC);
    chk_cnt++;
    if (set_hour !== 5'd23) begin
      $display("FAIL hour_dec_wrap: hour=%0d want 23", set_hour);
    end else pass_cnt++;
    press(M_MODE);
    press(M_DEC);
    chk_cnt++;
    if ({field, set_min} !== {3'd1, 6'd59}) begin
      $display("FAIL min_dec_wrap: field/min=%0d/%0d want 1/59", field, set_min);
    end else pass_cnt++;
    press(M_CAN);
  endtask

  task automatic test_day_clamp;
    set_cur(10, 10, 10, 31, 1, 2023);
    enter_field(4);
    press(M_INC);
    chk_cnt++;
    if ({set_day, set_month} !== {5'd28, 4'd2}) begin
      $display("FAIL month_clamp: day/month=%0d/%0d want 28/2", set_day, set_month);
    end else pass_cnt++;
    press(M_MODE);
    press(M_INC);
    chk_cnt++;
    if ({set_day, set_year} !== {5'd28, 14'd2024}) begin
      $display("FAIL year_keep_day: day/year=%0d/%0d want 28/2024", set_day, set_year);
    end else pass_cnt++;
    press(M_MODE);
    repeat (2) @(posedge clk); #1;
    chk_cnt++;
    if (ld_snap[22:0] !== {5'd28, 4'd2, 14'd2024}) begin
      $display("FAIL clamp_load: date=%h want %h", ld_snap[22:0], {5'd28, 4'd2, 14'd2024});
    end else pass_cnt++;
    set_cur(10, 10, 10, 28, 2, 2024);
    enter_field(3);
    press(M_INC);
    chk_cnt++;
    if (set_day !== 5'd29) begin
      $display("FAIL leap_day_29: day=%0d want 29", set_day);
    end else pass_cnt++;
    press(M_INC);
    chk_cnt++;
    if (set_day !== 5'd1) begin
      $display("FAIL leap_day_wrap: day=%0d want 1", set_day);
    end else pass_cnt++;
    press(M_CAN);
  endtask

  task automatic test_leap;
    set_cur(0, 0, 0, 28, 2, 1900);
    enter_field(3);
    press(M_INC);
    chk_cnt++;
    if (set_day !== 5'd1) begin
      $display("FAIL y1900_wrap: day=%0d want 1", set_day);
    end else pass_cnt++;
    press(M_DEC);
    chk_cnt++;
    if (set_day !== 5'd28) begin
      $display("FAIL y1900_dec: day=%0d want 28", set_day);
    end else pass_cnt++;
    press(M_CAN);
    set_cur(0, 0, 0, 28, 2, 2000);
    enter_field(3);
    press(M_INC);
    chk_cnt++;
    if (set_day !== 5'd29) begin
      $display("FAIL y2000_29: day=%0d want 29", set_day);
    end else pass_cnt++;
    press(M_CAN);
    set_cur(0, 0, 0, 29, 2, 2000);
    enter_field(5);
    press(M_INC);
    chk_cnt++;
    if ({set_day, set_year} !== {5'd28, 14'd2001}) begin
      $display("FAIL y2001_clamp: day/year=%0d/%0d want 28/2001", set_day, set_year);
    end else pass_cnt++;
    press(M_CAN);
    set_cur(0, 0, 0, 15, 6, 9999);
    enter_field(5);
    press(M_INC);
    chk_cnt++;
    if (set_year !== 14'd0) begin
      $display("FAIL year_max_wrap: year=%0d want 0", set_year);
    end else pass_cnt++;
    press(M_DEC);
    chk_cnt++;
    if (set_year !== 14'd9999) begin
      $display("FAIL year_zero_dec: year=%0d want 9999", set_year);
    end else pass_cnt++;
    press(M_CAN);
  endtask

  task automatic test_sanitise;
    set_cur(30, 60, 63, 0, 13, 12000);
    press(M_MODE);
    chk_cnt++;
    if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !==
        {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 14'd0}) begin
      $display("FAIL sanitise_all: %0d:%0d:%0d %0d/%0d/%0d want 0:0:0 1/1/0",
               set_hour, set_min, set_sec, set_day, set_month, set_year);
    end else pass_cnt++;
    press(M_CAN);
    set_cur(1, 2, 3, 31, 4, 2023);
    press(M_MODE);
    chk_cnt++;
    if (set_day !== 5'd30) begin
      $display("FAIL sanitise_day: day=%0d want 30", set_day);
    end else pass_cnt++;
    press(M_CAN);
  endtask

  task automatic test_cancel;
    base = load_cnt;
    set_cur(13, 45, 7, 15, 6, 2025);
    enter_field(3);
    press(M_INC);
    press(M_CAN);
    chk_cnt++;
    if ({editing, field, set_day} !== {1'b0, 3'd7, 5'd16}) begin
      $display("FAIL cancel_day: editing/field/day=%0d/%0d/%0d want 0/7/16", editing, field, set_day);
    end else pass_cnt++;
    press(M_MODE);
    press(M_CAN | M_MODE);
    chk_cnt++;
    if ({editing, field} !== {1'b0, 3'd7}) begin
      $display("FAIL cancel_beats_mode: editing/field=%0d/%0d want 0/7", editing, field);
    end else pass_cnt++;
    chk_cnt++;
    if (load_cnt - base !== 0) begin
      $display("FAIL cancel_no_load: pulses=%0d want 0", load_cnt - base);
    end else pass_cnt++;
  endtask

  task automatic test_inc_dec_rules;
    set_cur(13, 45, 7, 15, 6, 2025);
    press(M_MODE);
    press(M_INC | M_DEC);
    chk_cnt++;
    if ({field, set_hour} !== {3'd0, 5'd13}) begin
      $display("FAIL inc_and_dec: field/hour=%0d/%0d want 0/13", field, set_hour);
    end else pass_cnt++;
    btn_inc = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (set_hour !== 5'd14) begin
      $display("FAIL held_inc: hour=%0d want 14", set_hour);
    end else pass_cnt++;
    press(M_CAN);
  endtask

  task automatic test_blink;
    set_cur(13, 45, 7, 15, 6, 2025);
    press(M_MODE);
    btn_inc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    chk_cnt++;
    if ({field_blank, set_hour} !== {1'b0, 5'd14}) begin
      $display("FAIL blink_clear_inc: blank/hour=%0d/%0d want 0/14", field_blank, set_hour);
    end else pass_cnt++;
    repeat (7) @(posedge clk); #1;
    chk_cnt++;
    if (field_blank !== 1'b0) begin
      $display("FAIL blink_on_phase: blank=%0d want 0", field_blank);
    end else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (field_blank !== 1'b1) begin
      $display("FAIL blink_off_start: blank=%0d want 1", field_blank);
    end else pass_cnt++;
    repeat (7) @(posedge clk); #1;
    chk_cnt++;
    if (field_blank !== 1'b1) begin
      $display("FAIL blink_off_phase: blank=%0d want 1", field_blank);
    end else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (field_blank !== 1'b0) begin
      $display("FAIL blink_period: blank=%0d want 0", field_blank);
    end else pass_cnt++;
    repeat (8) @(posedge clk); #1;
    btn_inc = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (field_blank !== 1'b1) begin
      $display("FAIL blink_before_inc: blank=%0d want 1", field_blank);
    end else pass_cnt++;
    @(posedge clk); #1;
    btn_inc = 1'b0;
    chk_cnt++;
    if ({field_blank, set_hour} !== {1'b0, 5'd15}) begin
      $display("FAIL blink_reclear: blank/hour=%0d/%0d want 0/15", field_blank, set_hour);
    end else pass_cnt++;
    press(M_CAN);
    chk_cnt++;
    if (field_blank !== 1'b0) begin
      $display("FAIL blink_idle: blank=%0d want 0", field_blank);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_edit;
    base = load_cnt;
    set_cur(13, 45, 7, 15, 6, 2025);
    enter_field(5);
    chk_cnt++;
    if (field !== 3'd5) begin
      $display("FAIL pre_reset_year: field=%0d want 5", field);
    end else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if ({load, editing, field, field_blank} !== {1'b0, 1'b0, 3'd7, 1'b0}) begin
      $display("FAIL midreset_status: load/editing/field/blank=%0d/%0d/%0d/%0d want 0/0/7/0",
               load, editing, field, field_blank);
    end else pass_cnt++;
    chk_cnt++;
    if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !==
        {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 14'd2024}) begin
      $display("FAIL midreset_shadow: %0d:%0d:%0d %0d/%0d/%0d want 0:0:0 1/1/2024",
               set_hour, set_min, set_sec, set_day, set_month, set_year);
    end else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_cnt++;
    if (load_cnt - base !== 0) begin
      $display("FAIL midreset_no_load: pulses=%0d want 0", load_cnt - base);
    end else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    {btn_cancel, btn_dec, btn_inc, btn_mode} = 4'b0000;
    set_cur(13, 45, 7, 15, 6, 2025);
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_commit;
    test_time_wrap;
    test_day_clamp;
    test_leap;
    test_sanitise;
    test_cancel;
    test_inc_dec_rules;
    test_blink;
    test_reset_mid_edit;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
